wave_freq_meter: RTL and testbench
==================================

# wave_freq_meter

- Measures the fundamental frequency and period of an 8-bit sampled waveform (triangle, square or sine) using a hysteresis crossing detector.
- Sits beside the duty and phase measurement blocks in the analyzer path and consumes the same `wave_in`/`amplitude` stream that the DDS/LUT generator produces.
- Each gated measurement averages `NPER` periods, then runs a sequential divider to report frequency in Hz.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: sample clock in Hz. `CLK_FREQ*NPER` must be < 2^32.
- `NPER`, 4: periods averaged per measurement. Must be a power of 2, range 1..16.
- `TIMEOUT_CYC`, 50_000_000: cycles allowed without completion before abort.
- `CNT_W`, 32: counter width.

Ports:
- `clk`  in  1: sample clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `gate`  in  1: measurement enable (level).
- `wave_in`  in  8: unsigned sample, midscale 128.
- `amplitude`  in  16: peak code, same encoding as the generator (128..255 meaningful).
- `freq_hz`  out  32: measured frequency in Hz.
- `period_cyc`  out  32: mean period in clk cycles.
- `valid`  out  1: result ready.
- `busy`  out  1: measurement in progress.
- `timeout`  out  1: last measurement aborted on timeout.

## Operation
Reset:
- All outputs are 0 and the FSM is in IDLE.
- Reset is honoured in any state, including mid-DIVIDE.

Input and thresholds:
- `wave_in` is registered once as `s`.
- d = min(amplitude-128, 127) if amplitude > 128, else 0.
- h = max(d>>1, 2).
- hi_th = 128+h, lo_th = 128-h. Thresholds are recomputed every cycle.

Crossing detector:
- `armed` sets when s <= lo_th.
- A rising crossing fires for one cycle when armed=1 and s >= hi_th; `armed` clears on that same cycle.
- Result: exactly one event per period, so noise of less than ±h around midscale never double-counts.

FSM:
- IDLE:
  - busy=0; outputs hold their last values.
  - A gate rising edge (gate=1 with the previous gate=0) clears valid and timeout, clears `armed` and the timer, sets busy, and moves to WAIT_FIRST.
- WAIT_FIRST: on the first crossing, cnt<=0, ncross<=0, move to COUNT.
- COUNT:
  - cnt increments every cycle (saturating at 2^CNT_W-1).
  - Each crossing increments ncross.
  - When a crossing makes ncross==NPER, move to DIVIDE. cnt then equals the cycle distance between the first and the NPER-th subsequent crossing.
- DIVIDE:
  - Unsigned restoring division, 1 quotient bit per cycle, 32 cycles.
  - Quotient = floor(CLK_FREQ*NPER / cnt).
  - If cnt==0, the quotient is 0.
- DONE (entered after DIVIDE):
  - freq_hz <= quotient; period_cyc <= cnt >> log2(NPER); valid<=1; busy<=0.
  - Holds until gate=0, then moves to IDLE. Results and valid are kept.
- Abort on gate=0:
  - In WAIT_FIRST, COUNT or DIVIDE, gate=0 returns to IDLE on the next edge.
  - busy=0, valid stays 0, freq_hz and period_cyc are unchanged.
- Timeout:
  - The timer runs in WAIT_FIRST and COUNT from gate start.
  - When it reaches TIMEOUT_CYC-1: freq_hz<=0, period_cyc<=0, timeout<=1, valid<=1, busy<=0, move to DONE.
- Simultaneous events:
  - gate=0 takes priority over timeout and crossings.
  - Timeout takes priority over the final crossing on the same cycle.

## Timing
- `busy` rises 1 edge after the gate rising edge is sampled.
- `busy` falls 1 edge after gate=0 is sampled.
- Crossing event: 1 cycle after the sample arrives (input register), combinationally compared.
- `valid` and the result registers update exactly 33 edges after the edge on which the NPER-th crossing is registered: 1 edge to enter DIVIDE plus 32 divide cycles.
- Outputs change only on the DONE entry edge. They are stable while valid=1.
- A new gate rising edge while in DONE is not possible, since gate must fall first. Back-to-back measurements need gate low for at least 1 cycle.

## Test plan
- Square wave, 0/217 levels, period 500 cycles, amplitude=217, NPER=4, gate high:
  - Expect valid with cnt=2000, period_cyc=500, freq_hz=100000, timeout=0.
  - valid rises 33 edges after the 5th rising crossing.
- Triangle, amplitude=217, period 333 cycles:
  - Expect period_cyc=333, freq_hz=150150 (floor of 200e6/1332).
- Sine, amplitude=217, period 1000, plus ±3 LSB alternating ripple added near midscale (h=44):
  - Expect freq_hz=50000 with no spurious extra crossings.
- Constant wave_in=128, TIMEOUT_CYC=10000:
  - Expect timeout=1, valid=1, freq_hz=0, period_cyc=0 at 10000 cycles after gate start.
- Gate drops after 2 crossings:
  - Expect busy=0 next edge, valid=0, prior results unchanged.
  - Re-raise gate: a fresh measurement completes correctly.
- Assert rst during DIVIDE:
  - Expect all outputs 0 immediately (asynchronous).
  - After release, remain IDLE until a gate rising edge.

Source files
------------

// File: rtl/wave_freq_meter.sv
// Frequency/period meter for an 8-bit sampled waveform: a hysteresis crossing detector,
// a gated NPER-period counter and a 32-cycle restoring divider that produces Hz.
module wave_freq_meter #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned NPER        = 4,
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [7:0]  wave_in,
    input  logic [15:0] amplitude,
    output logic [31:0] freq_hz,
    output logic [31:0] period_cyc,
    output logic        valid,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned      LOG2N    = $clog2(NPER);
    localparam logic [31:0]      DIVIDEND = 32'(CLK_FREQ * NPER);
    localparam logic [31:0]      TMAX     = 32'(TIMEOUT_CYC - 1);
    localparam logic [4:0]       NLAST    = 5'(NPER - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_COUNT,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_s;
    logic             r_gate_d;
    logic             r_armed;
    logic [31:0]      r_timer;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_ncross;
    logic [31:0]      r_rem;
    logic [31:0]      r_dq;
    logic [4:0]       r_bit;

    logic [6:0]  w_d;
    logic [7:0]  w_half;
    logic [7:0]  w_h;
    logic [7:0]  w_hi_th;
    logic [7:0]  w_lo_th;
    logic        w_cross;
    logic [32:0] w_rem_sh;
    logic [32:0] w_div;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_dq_nx;

    // Hysteresis half-width from the peak code: half the excursion above midscale, at least 2.
    always_comb begin
        w_d = '0;
        if (amplitude > 16'd254) begin
            w_d = 7'd127;
        end else if (amplitude > 16'd128) begin
            w_d = amplitude[6:0];
        end
        w_half  = {1'b0, w_d} >> 1;
        w_h     = (w_half < 8'd2) ? 8'd2 : w_half;
        w_hi_th = 8'd128 + w_h;
        w_lo_th = 8'd128 - w_h;
        w_cross = r_armed && (r_s >= w_hi_th);
    end

    // One restoring-division step: remainder shifts in the next dividend bit from r_dq,
    // and the quotient bit shifts into r_dq from the bottom.
    always_comb begin
        w_rem_sh = {r_rem, r_dq[31]};
        w_div    = 33'(r_cnt);
        w_ge     = (w_rem_sh >= w_div);
        w_rem_nx = w_ge ? (w_rem_sh[31:0] - 32'(r_cnt)) : w_rem_sh[31:0];
        w_dq_nx  = {r_dq[30:0], w_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_s        <= '0;
            r_gate_d   <= 1'b1;
            r_armed    <= 1'b0;
            r_timer    <= '0;
            r_cnt      <= '0;
            r_ncross   <= '0;
            r_rem      <= '0;
            r_dq       <= '0;
            r_bit      <= '0;
            freq_hz    <= '0;
            period_cyc <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_s      <= wave_in;
            r_gate_d <= gate;

            if (w_cross) begin
                r_armed <= 1'b0;
            end else if (r_s <= w_lo_th) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (gate && !r_gate_d) begin
                        valid   <= 1'b0;
                        timeout <= 1'b0;
                        r_armed <= 1'b0;
                        r_timer <= '0;
                        busy    <= 1'b1;
                        r_state <= S_WAIT_FIRST;
                    end
                end

                S_WAIT_FIRST: begin
                    if (!gate) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_timer == TMAX) begin
                        freq_hz    <= '0;
                        period_cyc <= '0;
                        timeout    <= 1'b1;
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                        if (w_cross) begin
                            r_cnt    <= '0;
                            r_ncross <= '0;
                            r_state  <= S_COUNT;
                        end
                    end
                end

                S_COUNT: begin
                    if (!gate) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_timer == TMAX) begin
                        freq_hz    <= '0;
                        period_cyc <= '0;
                        timeout    <= 1'b1;
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (w_cross) begin
                            if (r_ncross == NLAST) begin
                                r_rem   <= '0;
                                r_dq    <= DIVIDEND;
                                r_bit   <= '0;
                                r_state <= S_DIVIDE;
                            end else begin
                                r_ncross <= r_ncross + 5'd1;
                            end
                        end
                    end
                end

                S_DIVIDE: begin
                    if (!gate) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_dq  <= w_dq_nx;
                        r_bit <= r_bit + 5'd1;
                        // Last quotient bit is taken straight from the step logic.
                        if (r_bit == 5'd31) begin
                            freq_hz    <= (r_cnt == '0) ? '0 : w_dq_nx;
                            period_cyc <= 32'(r_cnt >> LOG2N);
                            valid      <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (!gate) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_freq_meter.sv
// Self-checking bench for wave_freq_meter: periodic waveforms with random phase/shape,
// checked against a sample-history model of the hysteresis crossing rules.
module tb_wave_freq_meter;

    localparam int unsigned CLKF = 50_000_000;
    localparam int unsigned NP   = 4;
    localparam int unsigned TO   = 10000;

    logic        clk;
    logic        rst;
    logic        gate;
    logic [7:0]  wave_in;
    logic [15:0] amplitude;
    logic [31:0] freq_hz;
    logic [31:0] period_cyc;
    logic        valid;
    logic        busy;
    logic        timeout;

    wave_freq_meter #(
        .CLK_FREQ   (CLKF),
        .NPER       (NP),
        .TIMEOUT_CYC(TO),
        .CNT_W      (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gate      (gate),
        .wave_in   (wave_in),
        .amplitude (amplitude),
        .freq_hz   (freq_hz),
        .period_cyc(period_cyc),
        .valid     (valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          edge_n = 0;
    logic [7:0]  samp [65536];
    int          mode = 3;
    int          per = 500;
    int          amp = 217;
    int          ph = 0;
    int          rip = 0;
    int          checks = 0;
    int          errors = 0;
    longint      prev_freq = 0;
    longint      prev_period = 0;

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    function automatic logic [7:0] gen(input int t);
        int  u;
        int  v;
        int  lo;
        real x;
        u = (t + ph) % per;
        case (mode)
            0: v = (u < per / 2) ? 0 : amp;
            1: begin
                lo = 255 - amp;
                if (u < per / 2) v = lo + ((amp - lo) * 2 * u) / per;
                else             v = lo + ((amp - lo) * 2 * (per - u)) / per;
            end
            2: begin
                x = 128.0 + real'(amp - 128) * $sin(6.283185307179586 * real'(u) / real'(per));
                v = $rtoi(x + 0.5);
            end
            default: v = 128;
        endcase
        if (rip != 0 && v > 104 && v < 152) v = v + (((u % 2) == 1) ? 3 : -3);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    // Sample registered at edge k is the one driven in the half-cycle before it.
    initial begin
        logic [7:0] v;
        for (int i = 0; i < 65536; i++) samp[i] = 8'd128;
        wave_in = 8'd128;
        forever begin
            @(negedge clk);
            v = gen(edge_n);
            wave_in = v;
            if (edge_n + 1 < 65536) samp[edge_n + 1] = v;
        end
    end

    task automatic thresholds(output int hi, output int lo);
        int d;
        int h;
        d = (amp > 128) ? ((amp - 128 > 127) ? 127 : amp - 128) : 0;
        h = (d / 2 < 2) ? 2 : d / 2;
        hi = 128 + h;
        lo = 128 - h;
    endtask

    // Crossings among samples e0..upto: a sample at or above hi counts once a sample at
    // or below lo has been seen since gate start or since the previous crossing.
    task automatic scan(input int e0, input int upto, output int n, output int first, output int last);
        int  hi;
        int  lo;
        bit  seen_low;
        thresholds(hi, lo);
        n = 0; first = 0; last = 0; seen_low = 0;
        for (int k = e0; k <= upto; k++) begin
            if (n == NP + 1) break;
            if (seen_low && int'(samp[k]) >= hi) begin
                seen_low = 0;
                if (n == 0) first = k;
                last = k;
                n++;
            end else if (int'(samp[k]) <= lo) begin
                seen_low = 1;
            end
        end
    endtask

    // A crossing at sample k is acted on at edge k+1; timeout owns edge e0+TO.
    task automatic ref_model(input int e0, output bit to, output longint cnt, output int done_edge);
        int n;
        int first;
        int last;
        scan(e0, e0 + int'(TO) - 2, n, first, last);
        if (n == NP + 1) begin
            to = 0; cnt = longint'(last - first); done_edge = last + 33;
        end else begin
            to = 1; cnt = 0; done_edge = e0 + int'(TO);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic measure(input string tag);
        int     e0;
        int     done_edge;
        int     vedge;
        bit     got;
        bit     to;
        longint cnt;
        longint ef;
        longint ep;
        @(negedge clk);
        gate = 1'b1;
        e0 = edge_n + 1;
        @(negedge clk);
        chk({tag, ".busy_rise"}, 64'(busy), 64'd1);
        got = 0;
        for (int i = 0; i < int'(TO) + 2000; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                got = 1;
                break;
            end
        end
        vedge = edge_n;
        if (!got) chk({tag, ".wait_valid"}, 64'd0, 64'd1);
        ref_model(e0, to, cnt, done_edge);
        ef = to ? 0 : (longint'(CLKF) * longint'(NP)) / cnt;
        ep = to ? 0 : (cnt / longint'(NP));
        chk({tag, ".valid_edge"}, 64'(vedge), 64'(done_edge));
        chk({tag, ".freq_hz"}, 64'(freq_hz), 64'(ef));
        chk({tag, ".period_cyc"}, 64'(period_cyc), 64'(ep));
        chk({tag, ".timeout"}, 64'(timeout), 64'(to));
        chk({tag, ".busy_fall"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk({tag, ".hold"}, {31'd0, valid, freq_hz}, {31'd1, 32'(ef)});
        prev_freq = ef;
        prev_period = ep;
        gate = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_wave(input int m, input int p, input int a, input int r);
        mode = m; per = p; amp = a; rip = r;
        ph = $urandom_range(0, p - 1);
        amplitude = 16'(a);
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int n;
        int first;
        int last;
        bit saw_busy;
        rst = 1'b1;
        gate = 1'b0;
        amplitude = 16'd217;
        repeat (3) @(negedge clk);
        chk("rst.outputs", {freq_hz, period_cyc}, 64'd0);
        chk("rst.flags", {61'd0, valid, busy, timeout}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.flags", {61'd0, valid, busy, timeout}, 64'd0);

        set_wave(0, 500, 217, 0);
        measure("square");
        set_wave(1, 333, 217, 0);
        measure("triangle");
        set_wave(2, 1000, 217, 1);
        measure("sine_ripple");

        // Gate dropped mid-measurement: abort keeps prior results and leaves valid low.
        set_wave(0, 400, 200, 0);
        gate = 1'b1;
        repeat (1000) @(negedge clk);
        gate = 1'b0;
        @(negedge clk);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.valid", 64'(valid), 64'd0);
        chk("abort.freq_kept", 64'(freq_hz), 64'(prev_freq));
        chk("abort.period_kept", 64'(period_cyc), 64'(prev_period));
        @(negedge clk);
        measure("regate");

        set_wave(3, 100, 217, 0);
        measure("timeout");

        // Reset while dividing, then a gate held high across release must not start a run.
        set_wave(0, 300, 230, 0);
        gate = 1'b1;
        e0 = edge_n + 1;
        n = 0; last = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            scan(e0, edge_n, n, first, last);
            if (n == NP + 1 && edge_n >= last + 16) break;
        end
        chk("div.in_progress", {62'd0, busy, valid}, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("div_rst.outputs", {freq_hz, period_cyc}, 64'd0);
        chk("div_rst.flags", {61'd0, valid, busy, timeout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1;
        end
        chk("post_rst.idle", 64'(saw_busy), 64'd0);
        gate = 1'b0;
        @(negedge clk);
        measure("post_rst");

        for (int r = 0; r < 4; r++) begin
            set_wave($urandom_range(0, 2), $urandom_range(60, 900), $urandom_range(150, 255),
                     $urandom_range(0, 1));
            measure($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
